alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for a single shared ALU. Requests are arbitrated
//   round-robin, one operation is in flight at a time, and the result is held
//   in a registered response until its owner consumes it.
//
//   Handshake rule (request and response side alike): a transfer happens on a
//   rising clk edge where valid and ready are both high. Valid must not depend
//   on ready. Ready may depend on valid (here, request ready is the
//   combinational grant while IDLE).
//
// Ports
//   clk, arstn                 clock, asynchronous active-low reset
//   i_req_valid_0/1            requester has an operation pending
//   o_req_ready_0/1            requester's operation is accepted this edge
//   i_req_control_0/1          ALU opcode per requester
//   i_req_src_1_0/1, _2_0/1    operands per requester
//   o_rsp_valid_0/1            result held for that requester
//   i_rsp_ready_0/1            requester consumes the result
//   o_rsp_result, o_rsp_flags  shared response bus, flags {ovf, zero, neg, carry}
//   o_alu_control, o_alu_src_1/2   drive the shared ALU from the operand register
//   i_alu_result, i_alu_overflow/negative/carry   ALU outputs
//   o_busy                     high whenever the FSM is not IDLE
//   o_state                    debug view of the FSM state (0 IDLE, 1 EXEC, 2 RESP)
module alu_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int CONTROL_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     i_req_valid_0,
    input  logic                     i_req_valid_1,
    output logic                     o_req_ready_0,
    output logic                     o_req_ready_1,
    input  logic [CONTROL_WIDTH-1:0] i_req_control_0,
    input  logic [CONTROL_WIDTH-1:0] i_req_control_1,
    input  logic [DATA_WIDTH-1:0]    i_req_src_1_0,
    input  logic [DATA_WIDTH-1:0]    i_req_src_1_1,
    input  logic [DATA_WIDTH-1:0]    i_req_src_2_0,
    input  logic [DATA_WIDTH-1:0]    i_req_src_2_1,
    output logic                     o_rsp_valid_0,
    output logic                     o_rsp_valid_1,
    input  logic                     i_rsp_ready_0,
    input  logic                     i_rsp_ready_1,
    output logic [DATA_WIDTH-1:0]    o_rsp_result,
    output logic [3:0]               o_rsp_flags,
    output logic [CONTROL_WIDTH-1:0] o_alu_control,
    output logic [DATA_WIDTH-1:0]    o_alu_src_1,
    output logic [DATA_WIDTH-1:0]    o_alu_src_2,
    input  logic [DATA_WIDTH-1:0]    i_alu_result,
    input  logic                     i_alu_overflow,
    input  logic                     i_alu_negative,
    input  logic                     i_alu_carry,
    output logic                     o_busy,
    output logic [1:0]               o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;

    // last_grant: 1 means requester 1 won most recently, so requester 0 wins a tie.
    logic                     last_grant;
    logic                     owner;
    logic                     grant_0;
    logic                     grant_1;
    logic                     accept;
    logic                     owner_ack;

    logic [CONTROL_WIDTH-1:0] op_control;
    logic [DATA_WIDTH-1:0]    op_src_1;
    logic [DATA_WIDTH-1:0]    op_src_2;
    logic [DATA_WIDTH-1:0]    rsp_result;
    logic [3:0]               rsp_flags;

    // Grants are mutually exclusive by construction.
    always_comb begin
        grant_0 = i_req_valid_0 & (~i_req_valid_1 | last_grant);
        grant_1 = i_req_valid_1 & (~i_req_valid_0 | ~last_grant);
    end

    always_comb begin
        o_req_ready_0 = 1'b0;
        o_req_ready_1 = 1'b0;
        o_rsp_valid_0 = 1'b0;
        o_rsp_valid_1 = 1'b0;
        accept        = 1'b0;
        owner_ack     = owner ? i_rsp_ready_1 : i_rsp_ready_0;
        state_next    = state;
        case (state)
            IDLE: begin
                o_req_ready_0 = grant_0;
                o_req_ready_1 = grant_1;
                accept        = grant_0 | grant_1;
                if (accept) state_next = EXEC;
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                o_rsp_valid_0 = ~owner;
                o_rsp_valid_1 = owner;
                // The non-owner's ready never reaches the FSM.
                if (owner_ack) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand register: loaded only on an accepted request, so request inputs
    // that change while not ready have no effect and the ALU inputs hold the
    // last operands outside EXEC.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            op_control <= '0;
            op_src_1   <= '0;
            op_src_2   <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_control <= grant_1 ? i_req_control_1 : i_req_control_0;
            op_src_1   <= grant_1 ? i_req_src_1_1   : i_req_src_1_0;
            op_src_2   <= grant_1 ? i_req_src_2_1   : i_req_src_2_0;
            owner      <= grant_1;
            last_grant <= grant_1;
        end
    end

    // Response register: captured at the end of the single EXEC cycle, then
    // held untouched through RESP.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (state == EXEC) begin
            rsp_result <= i_alu_result;
            rsp_flags  <= {i_alu_overflow, (i_alu_result == '0), i_alu_negative, i_alu_carry};
        end
    end

    assign o_alu_control = op_control;
    assign o_alu_src_1   = op_src_1;
    assign o_alu_src_2   = op_src_2;
    assign o_rsp_result  = rsp_result;
    assign o_rsp_flags   = rsp_flags;
    assign o_busy        = (state != IDLE);
    assign o_state       = state;

endmodule
